// File: rtl/uart_rx_core.sv
// UART receiver: 1 start bit, PAYLOAD_BITS data bits LSB first, 1 stop bit, with BREAK detection.
// Define UART_RX_FRAME_ERR_EN to add the uart_rx_ferr framing-error strobe output.
module uart_rx_core #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 27000000,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic                    uart_rx_ferr
`endif
);

    localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CW             = $clog2(CYCLES_PER_BIT + 1);
    localparam int unsigned BW             = $clog2(PAYLOAD_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST    = CW'(HALF_BIT - 1);
    localparam logic [BW-1:0] BITS_LAST    = BW'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GUARD
    } state_t;

    state_t                  state, state_nxt;
    logic [1:0]              sync;
    logic                    rxs;
    logic [CW-1:0]           cyc, cyc_nxt;
    logic [BW-1:0]           bits, bits_nxt;
    logic [PAYLOAD_BITS-1:0] sr, sr_nxt;
    logic [PAYLOAD_BITS-1:0] data_nxt;
    logic                    valid_nxt;
    logic                    break_nxt;
`ifdef UART_RX_FRAME_ERR_EN
    logic                    ferr_nxt;
`endif

    assign rxs = sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync          <= 2'b11;
            state         <= IDLE;
            cyc           <= '0;
            bits          <= '0;
            sr            <= '0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            uart_rx_ferr  <= 1'b0;
`endif
        end else begin
            sync          <= {sync[0], uart_rxd};
            state         <= state_nxt;
            cyc           <= cyc_nxt;
            bits          <= bits_nxt;
            sr            <= sr_nxt;
            uart_rx_data  <= data_nxt;
            uart_rx_valid <= valid_nxt;
            uart_rx_break <= break_nxt;
`ifdef UART_RX_FRAME_ERR_EN
            uart_rx_ferr  <= ferr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        bits_nxt  = bits;
        sr_nxt    = sr;
        data_nxt  = uart_rx_data;
        valid_nxt = 1'b0;
        break_nxt = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cyc_nxt = '0;
                if (uart_rx_en && !rxs) begin
                    state_nxt = START;
                    bits_nxt  = '0;
                end
            end
            START: begin
                if (cyc == HALF_LAST) begin
                    cyc_nxt   = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            DATA: begin
                if (cyc == BIT_LAST) begin
                    cyc_nxt = '0;
                    // Shift right and insert at MSB so the first bit ends up in bit 0.
                    sr_nxt = sr >> 1;
                    sr_nxt[PAYLOAD_BITS-1] = rxs;
                    if (bits == BITS_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bits_nxt = bits + BW'(1);
                    end
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            STOP: begin
                if (cyc == BIT_LAST) begin
                    cyc_nxt = '0;
                    if (rxs) begin
                        data_nxt  = sr;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else if (sr == '0) begin
                        break_nxt = 1'b1;
                        state_nxt = GUARD;
                    end else begin
                        state_nxt = IDLE;
                    end
`ifdef UART_RX_FRAME_ERR_EN
                    ferr_nxt = !rxs;
`endif
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            GUARD: begin
                // Hold off until the line idles again so a long BREAK yields one pulse.
                cyc_nxt = '0;
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (!uart_rx_en) begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
            valid_nxt = 1'b0;
            break_nxt = 1'b0;
            data_nxt  = uart_rx_data;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_nxt  = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus queues expected strobes, a negedge monitor checks them.
// Build with UART_RX_FRAME_ERR_EN defined to also exercise uart_rx_ferr.
module tb_uart_rx_core;

    localparam int CPB  = 10;
    localparam int CPBD = 27000000 / 9600;
`ifdef UART_RX_FRAME_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic       b;
        logic       f;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn, en, rxd, rxd_b;
    logic       brk, valid, ferr;
    logic [7:0] data;
    logic       brk_b, valid_b, ferr_b;
    logic [7:0] data_b;

    int         checks   = 0;
    int         failures = 0;
    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    uart_rx_core #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(8)) dut (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd), .uart_rx_en(en),
        .uart_rx_break(brk), .uart_rx_valid(valid), .uart_rx_data(data)
`ifdef UART_RX_FRAME_ERR_EN
        , .uart_rx_ferr(ferr)
`endif
    );

    uart_rx_core #(.BIT_RATE(9600), .CLK_HZ(27000000), .PAYLOAD_BITS(8)) dut_b (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .uart_rx_en(en),
        .uart_rx_break(brk_b), .uart_rx_valid(valid_b), .uart_rx_data(data_b)
`ifdef UART_RX_FRAME_ERR_EN
        , .uart_rx_ferr(ferr_b)
`endif
    );

`ifndef UART_RX_FRAME_ERR_EN
    assign ferr   = 1'b0;
    assign ferr_b = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && (valid || brk || ferr)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual v=%b b=%b f=%b d=%h required none",
                         valid, brk, ferr, data);
            end else begin
                mon_e = q.pop_front();
                check("strobe{v,b,f,d}", {21'd0, valid, brk, ferr, data},
                      {21'd0, mon_e.v, mon_e.b, mon_e.f, mon_e.d});
            end
        end
    end

    task automatic hold(input logic b, input int n);
        rxd = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int abort_bit, input bit abort_rst);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                rxd = d[i];
                repeat (5) @(posedge clk);
                #1;
                if (abort_rst) resetn = 1'b0;
                else en = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                resetn = 1'b1;
                hold(d[i], 3);
            end else begin
                hold(d[i], CPB);
            end
        end
        hold(stop, CPB);
    endtask

    task automatic expect_good(input logic [7:0] d);
        q.push_back('{1'b1, 1'b0, 1'b0, d});
        last_good = d;
    endtask

    task automatic settle(input string name);
        hold(1'b1, 2 * CPB);
        check(name, q.size(), 0);
    endtask

    initial begin
        logic [10:0] fb;
        int          seen, pulses, breaks, idx;
        logic [7:0]  dat_b;

        resetn = 1'b0; en = 1'b1; rxd = 1'b1; rxd_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_break", brk, 0);
        check("rst_data", data, 8'h00);
        check("rst_ferr", ferr, 0);
        resetn = 1'b1;
        hold(1'b1, 20);

        expect_good(8'h55); send(8'h55, 1'b1, -1, 1'b0);
        expect_good(8'hA3); send(8'hA3, 1'b1, -1, 1'b0);
        settle("pair_drained");
        check("pair_data", data, 8'hA3);

        hold(1'b0, 3);
        hold(1'b1, 30);
        check("glitch_no_strobe", q.size(), 0);
        expect_good(8'h3C); send(8'h3C, 1'b1, -1, 1'b0);
        settle("after_glitch_drained");

        q.push_back('{1'b0, 1'b1, FE, last_good});
        send(8'h00, 1'b0, -1, 1'b0);
        hold(1'b0, 30 * CPB);
        check("break_seen", q.size(), 0);
        check("break_data_hold", data, 8'h3C);
        settle("break_release");
        expect_good(8'h01); send(8'h01, 1'b1, -1, 1'b0);
        settle("after_break_drained");
        check("after_break_data", data, 8'h01);

`ifdef UART_RX_FRAME_ERR_EN
        q.push_back('{1'b0, 1'b0, 1'b1, last_good});
`endif
        send(8'h7E, 1'b0, -1, 1'b0);
        settle("ferr_drained");
        check("ferr_data_hold", data, 8'h01);

        send(8'hFF, 1'b1, 4, 1'b0);
        en = 1'b1;
        settle("en_abort_no_strobe");
        check("en_abort_data_hold", data, 8'h01);
        expect_good(8'h81); send(8'h81, 1'b1, -1, 1'b0);
        settle("after_en_drained");
        check("after_en_data", data, 8'h81);

        send(8'hFF, 1'b1, 4, 1'b1);
        settle("rst_abort_no_strobe");
        check("rst_abort_data_clear", data, 8'h00);
        expect_good(8'h81); send(8'h81, 1'b1, -1, 1'b0);
        settle("after_rst_drained");
        check("after_rst_data", data, 8'h81);

        // Default-rate instance: frame bits 0=start, 1..8=data, 9=stop, 10=idle.
        fb = {1'b1, 1'b1, 8'h02, 1'b0};
        seen = -1; pulses = 0; breaks = 0; dat_b = 8'h00;
        for (int c = 0; c < 11 * CPBD; c++) begin
            idx = c / CPBD;
            if (idx > 10) idx = 10;
            rxd_b = fb[idx];
            @(posedge clk);
            #1;
            if (valid_b) begin
                pulses++;
                if (seen < 0) begin
                    seen  = c;
                    dat_b = data_b;
                end
            end
            if (brk_b || ferr_b) breaks++;
        end
        check("default_seen", (seen >= 0), 1);
        check("default_latency_window", (seen >= 9 * CPBD) && (seen <= 10 * CPBD + 10), 1);
        check("default_pulses", pulses, 1);
        check("default_data", dat_b, 8'h02);
        check("default_no_break", breaks, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
